// File: rtl/u3v_pkg.sv
// Shared constants, state encoding and frame descriptor for the U3V leader/trailer generator.
package u3v_pkg;

    localparam int unsigned DATA_W        = 32;
    localparam int unsigned IDX_W         = 4;

    localparam logic [31:0] U3V_LEADER_MAGIC  = 32'h4C56_3355;
    localparam logic [31:0] U3V_TRAILER_MAGIC = 32'h5456_3355;

    localparam int unsigned LEADER_SIZE   = 52;
    localparam int unsigned TRAILER_SIZE  = 32;
    localparam int unsigned LEADER_WORDS  = 13;
    localparam int unsigned TRAILER_WORDS = 8;

    localparam logic [IDX_W-1:0] LEADER_LAST  = IDX_W'(LEADER_WORDS - 1);
    localparam logic [IDX_W-1:0] TRAILER_LAST = IDX_W'(TRAILER_WORDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_ID = 3'd1,
        ST_LEADER  = 3'd2,
        ST_FRAME   = 3'd3,
        ST_TRAILER = 3'd4
    } state_e;

    // Per-frame fields captured at the accepted fval rise.
    typedef struct packed {
        logic [63:0] timestamp;
        logic [31:0] pixel_format;
        logic [15:0] size_x;
        logic [15:0] size_y;
        logic [15:0] offset_x;
        logic [15:0] offset_y;
    } frame_info_t;

endpackage

// File: rtl/fval_edge_detect.sv
// Registers frame-valid once and flags its rising and falling edges.
module fval_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic fval_i,
    output logic rise_c_o,
    output logic fall_c_o
);

    logic fval_q;

    // Delayed copy of fval for edge comparison.
    always_ff @(posedge clk) begin
        if (reset) begin
            fval_q <= 1'b0;
        end else begin
            fval_q <= fval_i;
        end
    end

    assign rise_c_o = fval_i & ~fval_q;
    assign fall_c_o = ~fval_i & fval_q;

endmodule

// File: rtl/u3v_leader_trailer_gen.sv
// Builds the U3V image leader and trailer around each accepted frame on a 32-bit valid/ready stream.
module u3v_leader_trailer_gen
    import u3v_pkg::*;
#(
    parameter logic [15:0] PAYLOAD_TYPE = 16'h0001,
    parameter logic [15:0] PADDING_X    = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_stream_enable,
    input  logic              i_fval,
    input  logic [63:0]       iv_blockid,
    input  logic [63:0]       iv_timestamp,
    input  logic [31:0]       iv_pixel_format,
    input  logic [15:0]       iv_size_x,
    input  logic [15:0]       iv_size_y,
    input  logic [15:0]       iv_offset_x,
    input  logic [15:0]       iv_offset_y,
    input  logic [31:0]       iv_payload_size,
    output logic              o_fval_rise,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] ov_data,
    output logic              o_sop,
    output logic              o_eop,
    output logic              o_leader,
    output logic              o_overrun
);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               wait_q, wait_d;
    logic               fall_pending_q, fall_pending_d;
    frame_info_t        info_q;
    logic [63:0]        blockid_q;
    logic [31:0]        payload_q;

    logic               valid_q, valid_d;
    logic               sop_q, sop_d;
    logic               eop_q, eop_d;
    logic               leader_q, leader_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [DATA_W-1:0]  word_c;

    logic               rise_c, fall_c;
    logic               run_c, xfer_c;
    logic               latch_info_c, latch_id_c, latch_payload_c;
    logic               fval_rise_c, overrun_c;

    fval_edge_detect u_edge (
        .clk      (clk),
        .reset    (reset),
        .fval_i   (i_fval),
        .rise_c_o (rise_c),
        .fall_c_o (fall_c)
    );

    assign run_c  = i_stream_enable & ~reset;
    assign xfer_c = valid_q & i_ready;

    // Frame sequencing: accept rise, wait for the counter, send leader, wait for fall, send trailer.
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        wait_d          = wait_q;
        fall_pending_d  = fall_pending_q;
        latch_info_c    = 1'b0;
        latch_id_c      = 1'b0;
        latch_payload_c = 1'b0;
        fval_rise_c     = 1'b0;
        overrun_c       = 1'b0;

        if (!run_c) begin
            state_d        = ST_IDLE;
            idx_d          = '0;
            wait_d         = 1'b0;
            fall_pending_d = 1'b0;
        end else begin
            if (rise_c && (state_q != ST_IDLE)) begin
                overrun_c = 1'b1;
            end
            // Only the first fall after an accepted rise counts; a rejected frame's fall is ignored.
            if (fall_c && !fall_pending_q &&
                ((state_q == ST_WAIT_ID) || (state_q == ST_LEADER))) begin
                fall_pending_d  = 1'b1;
                latch_payload_c = 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (rise_c) begin
                        fval_rise_c  = 1'b1;
                        latch_info_c = 1'b1;
                        wait_d       = 1'b0;
                        state_d      = ST_WAIT_ID;
                    end
                end
                ST_WAIT_ID: begin
                    // Second wait cycle: the counter's high word has settled.
                    if (wait_q) begin
                        latch_id_c = 1'b1;
                        wait_d     = 1'b0;
                        idx_d      = '0;
                        state_d    = ST_LEADER;
                    end else begin
                        wait_d = 1'b1;
                    end
                end
                ST_LEADER: begin
                    if (xfer_c) begin
                        if (idx_q == LEADER_LAST) begin
                            idx_d          = '0;
                            state_d        = fall_pending_d ? ST_TRAILER : ST_FRAME;
                            fall_pending_d = 1'b0;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                ST_FRAME: begin
                    if (fall_c) begin
                        latch_payload_c = 1'b1;
                        idx_d           = '0;
                        state_d         = ST_TRAILER;
                    end
                end
                ST_TRAILER: begin
                    if (xfer_c) begin
                        if (idx_q == TRAILER_LAST) begin
                            idx_d   = '0;
                            state_d = ST_IDLE;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Next stream word: flags and data for the word presented in the following cycle.
    always_comb begin
        valid_d  = (state_d == ST_LEADER) || (state_d == ST_TRAILER);
        leader_d = (state_d == ST_LEADER);
        sop_d    = valid_d && (idx_d == '0);
        eop_d    = valid_d && (idx_d == (leader_d ? LEADER_LAST : TRAILER_LAST));
        word_c   = '0;
        if (leader_d) begin
            case (idx_d)
                4'd0:    word_c = U3V_LEADER_MAGIC;
                4'd1:    word_c = {16'(LEADER_SIZE), 16'h0000};
                4'd2:    word_c = blockid_q[31:0];
                4'd3:    word_c = blockid_q[63:32];
                4'd4:    word_c = {PAYLOAD_TYPE, 16'h0000};
                4'd5:    word_c = info_q.timestamp[31:0];
                4'd6:    word_c = info_q.timestamp[63:32];
                4'd7:    word_c = info_q.pixel_format;
                4'd8:    word_c = {16'h0000, info_q.size_x};
                4'd9:    word_c = {16'h0000, info_q.size_y};
                4'd10:   word_c = {16'h0000, info_q.offset_x};
                4'd11:   word_c = {16'h0000, info_q.offset_y};
                4'd12:   word_c = {16'h0000, PADDING_X};
                default: word_c = '0;
            endcase
        end else begin
            case (idx_d)
                4'd0:    word_c = U3V_TRAILER_MAGIC;
                4'd1:    word_c = {16'(TRAILER_SIZE), 16'h0000};
                4'd2:    word_c = blockid_q[31:0];
                4'd3:    word_c = blockid_q[63:32];
                4'd4:    word_c = 32'h0000_0000;
                4'd5:    word_c = payload_q;
                4'd6:    word_c = 32'h0000_0000;
                4'd7:    word_c = {16'h0000, info_q.size_y};
                default: word_c = '0;
            endcase
        end
        data_d = valid_d ? word_c : '0;
    end

    // State, captured frame fields and registered stream outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            wait_q         <= 1'b0;
            fall_pending_q <= 1'b0;
            info_q         <= '0;
            blockid_q      <= '0;
            payload_q      <= '0;
            valid_q        <= 1'b0;
            sop_q          <= 1'b0;
            eop_q          <= 1'b0;
            leader_q       <= 1'b0;
            data_q         <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            wait_q         <= wait_d;
            fall_pending_q <= fall_pending_d;
            if (latch_info_c) begin
                info_q <= '{timestamp:    iv_timestamp,
                            pixel_format: iv_pixel_format,
                            size_x:       iv_size_x,
                            size_y:       iv_size_y,
                            offset_x:     iv_offset_x,
                            offset_y:     iv_offset_y};
            end
            if (latch_id_c) begin
                blockid_q <= iv_blockid;
            end
            if (latch_payload_c) begin
                payload_q <= iv_payload_size;
            end
            valid_q  <= valid_d;
            sop_q    <= sop_d;
            eop_q    <= eop_d;
            leader_q <= leader_d;
            data_q   <= data_d;
        end
    end

    assign o_fval_rise = fval_rise_c;
    assign o_overrun   = overrun_c;
    assign o_valid     = valid_q;
    assign o_sop       = sop_q;
    assign o_eop       = eop_q;
    assign o_leader    = leader_q;
    assign ov_data     = data_q;

endmodule
